// File: rtl/feature_frame_sequencer.sv
// Sensor frame sequencer: collects four channel words, waits for the classifier to settle, and presents the result.
// Optional partial-frame timeout is built with `define FEATURE_TIMEOUT_EN.
module feature_frame_sequencer #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [1:0]  s_chan,
  input  logic [15:0] s_data,
  output logic [15:0] feat_temp,
  output logic [15:0] feat_light,
  output logic [15:0] feat_voc,
  output logic [15:0] feat_press,
  input  logic [2:0]  cls_id,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [2:0]  r_class_id,
  output logic [4:0]  r_onehot,
  output logic [7:0]  r_frame_cnt,
  output logic        err_dup,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETTLE  = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  mask_r;
  logic [3:0]  settle_cnt_r;
  logic        s_ready_r;
  logic        r_valid_r;
  logic [2:0]  r_class_id_r;
  logic [7:0]  r_frame_cnt_r;
  logic        err_dup_r;
  logic [15:0] feat_temp_r;
  logic [15:0] feat_light_r;
  logic [15:0] feat_voc_r;
  logic [15:0] feat_press_r;

  logic        xfer_s;
  logic [3:0]  chan_bit_s;
  logic [3:0]  mask_next_s;

  // Classes 4..7 all land on the top bit.
  function automatic logic [4:0] onehot_f(input logic [2:0] id);
    case (id)
      3'd0:    onehot_f = 5'b00001;
      3'd1:    onehot_f = 5'b00010;
      3'd2:    onehot_f = 5'b00100;
      3'd3:    onehot_f = 5'b01000;
      default: onehot_f = 5'b10000;
    endcase
  endfunction

  assign xfer_s      = s_valid & s_ready_r;
  assign chan_bit_s  = 4'b0001 << s_chan;
  assign mask_next_s = mask_r | chan_bit_s;

`ifdef FEATURE_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  logic [IDLE_W-1:0] idle_r;
  logic              err_timeout_r;
  assign err_timeout = err_timeout_r;
`else
  assign err_timeout = 1'b0;
`endif

  // Frame collection FSM, feature registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= COLLECT;
      mask_r        <= 4'h0;
      settle_cnt_r  <= 4'd0;
      s_ready_r     <= 1'b0;
      r_valid_r     <= 1'b0;
      r_class_id_r  <= 3'd0;
      r_frame_cnt_r <= 8'd0;
      err_dup_r     <= 1'b0;
      feat_temp_r   <= 16'h0000;
      feat_light_r  <= 16'h0000;
      feat_voc_r    <= 16'h0000;
      feat_press_r  <= 16'h0000;
`ifdef FEATURE_TIMEOUT_EN
      idle_r        <= '0;
      err_timeout_r <= 1'b0;
`endif
    end else begin
      err_dup_r <= 1'b0;
`ifdef FEATURE_TIMEOUT_EN
      err_timeout_r <= 1'b0;
`endif
      case (state_r)
        COLLECT: begin
          s_ready_r <= 1'b1;
          if (xfer_s) begin
            case (s_chan)
              2'd0:    feat_temp_r  <= s_data;
              2'd1:    feat_light_r <= s_data;
              2'd2:    feat_voc_r   <= s_data;
              default: feat_press_r <= s_data;
            endcase
            err_dup_r <= |(mask_r & chan_bit_s);
            mask_r    <= mask_next_s;
`ifdef FEATURE_TIMEOUT_EN
            idle_r    <= '0;
`endif
            if (mask_next_s == 4'hF) begin
              state_r      <= SETTLE;
              settle_cnt_r <= 4'(SETTLE_CYCLES);
              s_ready_r    <= 1'b0;
            end
          end else begin
`ifdef FEATURE_TIMEOUT_EN
            // Idle time only accumulates inside a partial frame.
            if (mask_r != 4'h0 && mask_r != 4'hF) begin
              if (idle_r == IDLE_LAST) begin
                mask_r        <= 4'h0;
                idle_r        <= '0;
                err_timeout_r <= 1'b1;
              end else begin
                idle_r <= idle_r + 1'b1;
              end
            end else begin
              idle_r <= '0;
            end
`endif
          end
        end
        SETTLE: begin
          s_ready_r <= 1'b0;
          if (settle_cnt_r == 4'd0) begin
            r_class_id_r <= cls_id;
            r_valid_r    <= 1'b1;
            state_r      <= HOLD;
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end
        HOLD: begin
          if (r_valid_r && r_ready) begin
            r_valid_r     <= 1'b0;
            mask_r        <= 4'h0;
            r_frame_cnt_r <= r_frame_cnt_r + 8'd1;
            s_ready_r     <= 1'b1;
            state_r       <= COLLECT;
          end else begin
            s_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= COLLECT;
          mask_r    <= 4'h0;
          s_ready_r <= 1'b0;
          r_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_r;
  assign r_valid     = r_valid_r;
  assign r_class_id  = r_class_id_r;
  assign r_onehot    = onehot_f(r_class_id_r);
  assign r_frame_cnt = r_frame_cnt_r;
  assign err_dup     = err_dup_r;
  assign feat_temp   = feat_temp_r;
  assign feat_light  = feat_light_r;
  assign feat_voc    = feat_voc_r;
  assign feat_press  = feat_press_r;

endmodule

// File: tb/tb_feature_frame_sequencer.sv
// Directed, table-driven bench for feature_frame_sequencer (SETTLE_CYCLES=2, TIMEOUT_CYCLES=8).
module tb_feature_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  s_chan = 2'd0;
  logic [15:0] s_data = 16'h0000;
  logic [15:0] feat_temp, feat_light, feat_voc, feat_press;
  logic [2:0]  cls_id = 3'd0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [2:0]  r_class_id;
  logic [4:0]  r_onehot;
  logic [7:0]  r_frame_cnt;
  logic        err_dup;
  logic        err_timeout;

  int pass_cnt = 0;
  int total_cnt = 0;
  int dup_pulses = 0;
  int to_pulses = 0;
  int rv_rises = 0;
  logic rv_prev = 1'b0;

  feature_frame_sequencer #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_chan(s_chan), .s_data(s_data), .feat_temp(feat_temp), .feat_light(feat_light),
    .feat_voc(feat_voc), .feat_press(feat_press), .cls_id(cls_id), .r_valid(r_valid),
    .r_ready(r_ready), .r_class_id(r_class_id), .r_onehot(r_onehot),
    .r_frame_cnt(r_frame_cnt), .err_dup(err_dup), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Pulse and result-rise monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (err_dup) dup_pulses <= dup_pulses + 1;
    if (err_timeout) to_pulses <= to_pulses + 1;
    if (r_valid && !rv_prev) rv_rises <= rv_rises + 1;
    rv_prev <= r_valid;
  end

  typedef struct {
    logic [15:0] d0, d1, d2, d3;
    logic [2:0]  cls;
    logic [4:0]  exp_onehot;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send_word(input logic [1:0] ch, input logic [15:0] d);
    int n = 0;
    s_valid = 1'b1; s_chan = ch; s_data = d;
    @(negedge clk);
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (!s_ready) check("send_word_ready_wait", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] d0, d1, d2, d3, input logic [2:0] cls, output int lat);
    cls_id = cls;
    send_word(2'd0, d0); send_word(2'd1, d1); send_word(2'd2, d2); send_word(2'd3, d3);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); lat++; #1;
      if (r_valid) break;
    end
    if (!r_valid) lat = -1;
  endtask

  task automatic accept();
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, rv0, dp0, bad_ready, bad_stable, bad_lat;
    logic [2:0] sv_cls; logic [4:0] sv_oh; logic [7:0] sv_cnt; logic [15:0] sv_voc;

    vecs[0] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 3'd3, 5'b01000, 8'd0};
    vecs[1] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 3'd0, 5'b00001, 8'd1};
    vecs[2] = '{16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, 3'd4, 5'b10000, 8'd2};
    vecs[3] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 3'd5, 5'b10000, 8'd3};
    vecs[4] = '{16'hFFFF, 16'h0000, 16'h1234, 16'hABCD, 3'd7, 5'b10000, 8'd4};
    vecs[5] = '{16'h7E57, 16'h8001, 16'hC0DE, 16'h0BAD, 3'd1, 5'b00010, 8'd5};

    // Reset values
    #2;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_r_valid", 32'(r_valid), 32'd0);
    check("rst_r_onehot", 32'(r_onehot), 32'h01);
    check("rst_r_class_id", 32'(r_class_id), 32'd0);
    check("rst_r_frame_cnt", 32'(r_frame_cnt), 32'd0);
    check("rst_feat_temp", 32'(feat_temp), 32'd0);
    check("rst_feat_press", 32'(feat_press), 32'd0);
    check("rst_err_dup", 32'(err_dup), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 check("s_ready_before_edge", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check("s_ready_first_edge", 32'(s_ready), 32'd1);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].cls, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("v%0d_class", i), 32'(r_class_id), 32'(vecs[i].cls));
      check($sformatf("v%0d_onehot", i), 32'(r_onehot), 32'(vecs[i].exp_onehot));
      check($sformatf("v%0d_frame_cnt", i), 32'(r_frame_cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_feat_temp", i), 32'(feat_temp), 32'(vecs[i].d0));
      check($sformatf("v%0d_feat_light", i), 32'(feat_light), 32'(vecs[i].d1));
      check($sformatf("v%0d_feat_voc", i), 32'(feat_voc), 32'(vecs[i].d2));
      check($sformatf("v%0d_feat_press", i), 32'(feat_press), 32'(vecs[i].d3));
      accept();
      check($sformatf("v%0d_r_valid_clr", i), 32'(r_valid), 32'd0);
      check($sformatf("v%0d_s_ready_back", i), 32'(s_ready), 32'd1);
    end

    // Duplicate channel within a frame
    dp0 = dup_pulses; rv0 = rv_rises;
    cls_id = 3'd2;
    send_word(2'd1, 16'h0011);
    check("dup_no_pulse_first", 32'(err_dup), 32'd0);
    send_word(2'd1, 16'h0022);
    check("dup_pulse", 32'(err_dup), 32'd1);
    send_word(2'd0, 16'h0033); send_word(2'd2, 16'h0044); send_word(2'd3, 16'h0055);
    repeat (4) @(posedge clk); #1;
    check("dup_result_valid", 32'(r_valid), 32'd1);
    check("dup_feat_light", 32'(feat_light), 32'h0022);
    check("dup_frame_cnt", 32'(r_frame_cnt), 32'd6);
    accept();
    repeat (8) @(posedge clk); #1;
    check("dup_pulse_count", 32'(dup_pulses - dp0), 32'd1);
    check("dup_single_result", 32'(rv_rises - rv0), 32'd1);

    // Back-pressure in HOLD
    run_frame(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 3'd4, lat);
    sv_cls = r_class_id; sv_oh = r_onehot; sv_cnt = r_frame_cnt; sv_voc = feat_voc;
    s_valid = 1'b1; s_chan = 2'd2; s_data = 16'hBEEF; cls_id = 3'd1;
    bad_ready = 0; bad_stable = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_ready !== 1'b0) bad_ready++;
      if (r_valid !== 1'b1 || r_class_id !== sv_cls || r_onehot !== sv_oh ||
          r_frame_cnt !== sv_cnt || feat_voc !== sv_voc) bad_stable++;
    end
    check("hold_s_ready_low", 32'(bad_ready), 32'd0);
    check("hold_outputs_stable", 32'(bad_stable), 32'd0);
    check("hold_class_value", 32'(sv_cls), 32'd4);
    check("hold_cnt_value", 32'(sv_cnt), 32'd7);
    s_valid = 1'b0;
    accept();
    check("hold_released_valid", 32'(r_valid), 32'd0);
    check("hold_released_ready", 32'(s_ready), 32'd1);
    check("hold_cnt_incr", 32'(r_frame_cnt), 32'd8);

    // Reset pulse during SETTLE
    rv0 = rv_rises; dp0 = dup_pulses;
    cls_id = 3'd3;
    send_word(2'd0, 16'h1); send_word(2'd1, 16'h2); send_word(2'd2, 16'h3); send_word(2'd3, 16'h4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("settle_rst_r_valid", 32'(r_valid), 32'd0);
    check("settle_rst_feat_temp", 32'(feat_temp), 32'd0);
    check("settle_rst_cnt", 32'(r_frame_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    r_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    r_ready = 1'b0;
    check("settle_rst_no_result", 32'(rv_rises - rv0), 32'd0);
    check("settle_rst_no_err", 32'(dup_pulses - dp0), 32'd0);
`ifndef FEATURE_TIMEOUT_EN
    // A partial frame waits indefinitely
    cls_id = 3'd1;
    send_word(2'd0, 16'h00AA);
    repeat (50) @(posedge clk); #1;
    check("partial_no_timeout", 32'(to_pulses), 32'd0);
    check("partial_still_ready", 32'(s_ready), 32'd1);
    check("partial_no_result", 32'(r_valid), 32'd0);
    send_word(2'd1, 16'h00BB); send_word(2'd2, 16'h00CC); send_word(2'd3, 16'h00DD);
    repeat (3) @(posedge clk); #1;
`else
    run_frame(16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD, 3'd1, lat);
`endif
    check("post_rst_result", 32'(r_valid), 32'd1);
    check("post_rst_cnt", 32'(r_frame_cnt), 32'd0);
    check("post_rst_feat_temp", 32'(feat_temp), 32'h00AA);
    accept();

`ifdef FEATURE_TIMEOUT_EN
    // Partial-frame timeout
    do_reset();
    send_word(2'd0, 16'h0099);
    repeat (12) @(posedge clk); #1;
    check("timeout_pulse_count", 32'(to_pulses), 32'd1);
    run_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 3'd2, lat);
    check("timeout_next_latency", 32'(lat), 32'd3);
    check("timeout_next_class", 32'(r_class_id), 32'd2);
    accept();
`endif

    // Frame counter wrap over 257 frames
    do_reset();
    bad_lat = 0;
    for (int f = 1; f <= 257; f++) begin
      run_frame(16'(f), 16'(f + 1), 16'(f + 2), 16'(f + 3), 3'(f), lat);
      if (lat != 3) bad_lat++;
      if (f == 1) check("wrap_frame1", 32'(r_frame_cnt), 32'd0);
      if (f == 256) check("wrap_frame256", 32'(r_frame_cnt), 32'd255);
      if (f == 257) check("wrap_frame257", 32'(r_frame_cnt), 32'd0);
      accept();
    end
    check("wrap_latency_all", 32'(bad_lat), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/feature_frame_sequencer.md
FEATURE_FRAME_SEQUENCER -- requirements
Module: feature_frame_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2: cycles the captured frame is held stable before sampling the classifier result (range 1..15).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed within a partial frame (used only with FEATURE_TIMEOUT_EN).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port s_valid, input, 1 bit: sensor word valid, from the I2C reader.
REQ-006 The block SHALL have port s_ready, output, 1 bit: sequencer accepts the sensor word.
REQ-007 The block SHALL have port s_chan, input, 2 bits: channel (0 temp, 1 light, 2 voc, 3 press).
REQ-008 The block SHALL have port s_data, input, 16 bits: raw sensor word.
REQ-009 The block SHALL have ports feat_temp, feat_light, feat_voc, feat_press, output, 16 bits each: registered features driven into the classifier.
REQ-010 The block SHALL have port cls_id, input, 3 bits: argmax class index returned by the classifier.
REQ-011 The block SHALL have port r_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port r_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port r_class_id, output, 3 bits: captured class index.
REQ-014 The block SHALL have port r_onehot, output, 5 bits: one-hot of r_class_id; values above 4 map to 5'b10000.
REQ-015 The block SHALL have port r_frame_cnt, output, 8 bits: sequence number of the presented result.
REQ-016 The block SHALL have port err_dup, output, 1 bit: one-cycle pulse when a channel arrives twice in one frame.
REQ-017 The block SHALL have port err_timeout, output, 1 bit: one-cycle pulse when a partial frame is discarded.

Function
REQ-018 The FSM SHALL have the states COLLECT, SETTLE and HOLD.
REQ-019 An input transfer SHALL occur on a rising edge with s_valid=1 and s_ready=1, and s_ready SHALL be 1 only in COLLECT.
REQ-020 On transfer, s_data SHALL be written to the feature register selected by s_chan, and the corresponding bit of a 4-bit mask SHALL be set.
REQ-021 A transfer to a channel whose mask bit is already set SHALL overwrite the register, and err_dup SHALL pulse high in the next cycle.
REQ-022 The transfer that completes mask=4'hF SHALL move the FSM to SETTLE and load the settle counter with SETTLE_CYCLES.
REQ-023 In SETTLE, the feature registers SHALL be frozen and the counter SHALL decrement once per cycle.
REQ-024 The cycle the settle counter reaches 0, r_class_id SHALL be loaded with cls_id, r_valid SHALL be set on the next edge, and the FSM SHALL enter HOLD.
REQ-025 Latency from the completing transfer edge to r_valid=1 SHALL be SETTLE_CYCLES+1 cycles.
REQ-026 In HOLD, r_valid, r_class_id, r_onehot and r_frame_cnt SHALL remain stable until r_ready=1.
REQ-027 On an r_valid & r_ready edge, r_valid SHALL clear, the mask SHALL clear, r_frame_cnt SHALL increment modulo 256 (255 wraps to 0), and the FSM SHALL return to COLLECT.
REQ-028 Feature registers SHALL retain their last values after a frame completes; only the mask gates frame completion.
REQ-029 r_ready asserted while r_valid=0 SHALL be ignored.
REQ-030 r_onehot SHALL be derived from the registered r_class_id, with no combinational path from cls_id.

Reset
REQ-031 While rst_n=0, the FSM SHALL be in COLLECT and the mask, counters, feature registers, r_class_id and r_frame_cnt SHALL all be 0.
REQ-032 While rst_n=0, r_valid, s_ready, err_dup and err_timeout SHALL be 0, and r_onehot SHALL be 5'b00001.
REQ-033 s_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-034 Reset asserted in any state, mid-frame or in HOLD, SHALL abandon the frame and result immediately, with no pulse on any error output.

Configuration
REQ-035 With FEATURE_TIMEOUT_EN defined: in COLLECT with mask nonzero and not 4'hF, an idle counter SHALL count cycles without a transfer and SHALL be cleared by any transfer.
REQ-036 With FEATURE_TIMEOUT_EN defined, when the idle counter reaches TIMEOUT_CYCLES the mask SHALL clear and err_timeout SHALL pulse high for one cycle.
REQ-037 With FEATURE_TIMEOUT_EN defined, the idle counter SHALL NOT run while the mask is 0.
REQ-038 Without FEATURE_TIMEOUT_EN, no idle counter SHALL exist, err_timeout SHALL be tied to 0, and a partial frame SHALL wait indefinitely.

Verification
REQ-039 Scenario: reset, then send chan 0..3 with data 0x0100, 0x0200, 0x0300, 0x0400 back-to-back, cls_id=3, r_ready=1 -> r_valid high exactly 3 cycles after the 4th transfer; r_class_id=3; r_onehot=5'b01000; r_frame_cnt=0.
REQ-040 Scenario: send chan 1 twice (0x0011, then 0x0022), then chans 0, 2, 3 -> one err_dup pulse; feat_light=0x0022; a single result is produced.
REQ-041 Scenario: hold r_ready=0 for 10 cycles in HOLD while s_valid=1 -> s_ready=0 throughout; outputs stable; accepting then resumes COLLECT.
REQ-042 Scenario: run 257 complete frames -> r_frame_cnt sequence ends 255, 0 at frames 256 and 257.
REQ-043 Scenario: pulse rst_n low during SETTLE -> r_valid never rises; mask cleared; next full frame yields r_frame_cnt=0.
REQ-044 Scenario: with FEATURE_TIMEOUT_EN and TIMEOUT_CYCLES=8, send chan 0 then idle 8 cycles -> err_timeout pulses once; next four channels produce a normal result.
